// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one-entry fetch buffer in front of a handshaked instruction
// memory, with stall generation, misalignment detection and a sticky response timeout.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_error,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic        r_buf_valid;
    logic [31:0] r_buf_addr;
    logic [31:0] r_buf_data;
    logic [31:0] r_req_addr;
    logic [7:0]  r_timer;
    logic        r_bus_error;

    logic w_hit;
    logic w_misaligned;

    assign w_hit        = r_buf_valid && (i_pc == r_buf_addr);
    assign w_misaligned = (i_pc[1:0] != 2'b00);

    assign o_instr      = w_hit ? r_buf_data : NOP_INSTR;
    assign o_stall      = !w_hit;
    assign o_misaligned = w_misaligned;
    assign o_bus_error  = r_bus_error;
    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_imem_addr;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= 32'h0;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 32'h0;
            r_buf_data  <= 32'h0;
            r_req_addr  <= 32'h0;
            r_timer     <= 8'h0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_hit && !w_misaligned && !r_bus_error) begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= i_pc;
                        r_req_addr  <= i_pc;
                    end
                end
                S_REQ: begin
                    // Address is latched; later pc changes do not disturb the request.
                    if (i_imem_gnt) begin
                        r_state    <= S_WAIT;
                        r_imem_req <= 1'b0;
                        r_timer    <= 8'h0;
                    end
                end
                S_WAIT: begin
                    // A response always wins over a timeout in the same cycle.
                    if (i_imem_rvalid) begin
                        r_state     <= S_IDLE;
                        r_buf_valid <= 1'b1;
                        r_buf_addr  <= r_req_addr;
                        r_buf_data  <= i_imem_rdata;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state     <= S_IDLE;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// every output compared each cycle against a transaction-level reference model.
module tb_instr_fetch_unit;

    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        misaligned;
    logic        bus_error;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending request, a count of cycles spent waiting, a buffer, an error.
    logic        m_pending;
    logic        m_waiting;
    int          m_waited;
    logic [31:0] m_addr;
    logic        m_bv;
    logic [31:0] m_ba;
    logic [31:0] m_bd;
    logic        m_err;

    instr_fetch_unit #(
        .TIMEOUT  (TO),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pc         (pc),
        .o_instr      (instr),
        .o_stall      (stall),
        .o_misaligned (misaligned),
        .o_bus_error  (bus_error),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit();
        return m_bv && (pc == m_ba);
    endfunction

    task automatic model_clear();
        m_pending = 1'b0;
        m_waiting = 1'b0;
        m_waited  = 0;
        m_addr    = 32'h0;
        m_bv      = 1'b0;
        m_ba      = 32'h0;
        m_bd      = 32'h0;
        m_err     = 1'b0;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_clear();
        end else if (m_pending) begin
            if (gnt) begin
                m_pending = 1'b0;
                m_waiting = 1'b1;
                m_waited  = 0;
            end
        end else if (m_waiting) begin
            m_waited++;
            if (rvalid) begin
                m_bv      = 1'b1;
                m_ba      = m_addr;
                m_bd      = rdata;
                m_waiting = 1'b0;
            end else if (m_waited == TO) begin
                m_err     = 1'b1;
                m_waiting = 1'b0;
            end
        end else if (!m_hit() && pc[1:0] == 2'b00 && !m_err) begin
            m_pending = 1'b1;
            m_addr    = pc;
        end
    endtask

    // Drive inputs at the falling edge, then compare every output with the model.
    task automatic drive(input logic rst, input logic [31:0] p, input logic g, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        reset  = rst;
        pc     = p;
        gnt    = g;
        rvalid = rv;
        rdata  = rd;
        #1;
        check_eq("instr",      instr,      m_hit() ? m_bd : NOP);
        check_eq("stall",      {31'b0, stall},      {31'b0, !m_hit()});
        check_eq("misaligned", {31'b0, misaligned}, {31'b0, (p[1:0] != 2'b00)});
        check_eq("bus_error",  {31'b0, bus_error},  {31'b0, m_err});
        check_eq("imem_req",   {31'b0, imem_req},   {31'b0, m_pending});
        check_eq("imem_addr",  imem_addr,  m_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic cyc(input logic rst, input logic [31:0] p, input logic g, input logic rv,
                       input logic [31:0] rd);
        drive(rst, p, g, rv, rd);
        tick();
    endtask

    logic [31:0] pc_pool [6];

    initial begin
        pc_pool[0] = 32'h0;
        pc_pool[1] = 32'h4;
        pc_pool[2] = 32'h8;
        pc_pool[3] = 32'hC;
        pc_pool[4] = 32'hFFFFFFFC;
        pc_pool[5] = 32'h6;

        reset = 1'b0; pc = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        repeat (2) @(posedge clk);
        model_clear();

        // Reset state, with reset still asserted.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("rst_stall", {31'b0, stall}, 32'h1);
        check_eq("rst_req",   {31'b0, imem_req}, 32'h0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_instr", instr, NOP);
        tick();

        // Minimum-latency miss on pc=0.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("lat_c0_stall", {31'b0, stall}, 32'h1);
        tick();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("lat_c1_req",  {31'b0, imem_req}, 32'h1);
        check_eq("lat_c1_addr", imem_addr, 32'h0);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h00500113);
        check_eq("lat_c2_stall", {31'b0, stall}, 32'h1);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("lat_c3_instr", instr, 32'h00500113);
        check_eq("lat_c3_stall", {31'b0, stall}, 32'h0);
        tick();

        // Hold on a hit, then step to pc=4.
        repeat (3) begin
            drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
            check_eq("hold_noreq", {31'b0, imem_req}, 32'h0);
            tick();
        end
        cyc(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
        check_eq("pc4_addr", imem_addr, 32'h4);
        tick();
        cyc(1'b1, 32'h4, 1'b0, 1'b1, 32'h11111111);
        cyc(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);

        // Grant delayed while pc moves 8 -> 12; fill is tagged 8, then 12 is fetched.
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
            check_eq("dly_addr", imem_addr, 32'h8);
            tick();
        end
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 32'h88888888);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
        check_eq("stale_stall", {31'b0, stall}, 32'h1);
        tick();
        drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h0);
        check_eq("refetch_addr", imem_addr, 32'hC);
        tick();
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 32'hCCCCCCCC);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
        check_eq("pc12_instr", instr, 32'hCCCCCCCC);
        tick();

        // Response timeout on pc=16.
        cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
        repeat (TO + 4) cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
        check_eq("to_err",   {31'b0, bus_error}, 32'h1);
        check_eq("to_noreq", {31'b0, imem_req}, 32'h0);
        check_eq("to_stall", {31'b0, stall}, 32'h1);
        tick();
        cyc(1'b0, 32'h10, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        check_eq("to_clr", {31'b0, bus_error}, 32'h0);
        tick();
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h10, 1'b0, 1'b1, 32'h10101010);

        // Misaligned pc, then realign to 8.
        repeat (4) begin
            drive(1'b1, 32'h6, 1'b1, 1'b1, 32'h0);
            check_eq("mis_flag",  {31'b0, misaligned}, 32'h1);
            check_eq("mis_instr", instr, 32'h00000013);
            check_eq("mis_noreq", {31'b0, imem_req}, 32'h0);
            tick();
        end
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h8, 1'b0, 1'b1, 32'h80808080);
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);

        // Reset during WAIT, then a late response that must be discarded.
        cyc(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h20, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h20, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h20, 1'b0, 1'b1, 32'hDEADBEEF);
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        check_eq("late_stall", {31'b0, stall}, 32'h1);
        check_eq("late_req",   {31'b0, imem_req}, 32'h1);
        check_eq("late_addr",  imem_addr, 32'h20);
        tick();
        cyc(1'b1, 32'h20, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 32'h20, 1'b0, 1'b1, 32'h20202020);

        // Randomized traffic; every cycle checked against the model.
        begin
            logic [31:0] p;
            p = 32'h0;
            for (int i = 0; i < 4000; i++) begin
                logic rst;
                if ($urandom_range(0, 3) == 0) p = pc_pool[$urandom_range(0, 5)];
                rst = ($urandom_range(0, 99) != 0);
                cyc(rst, p, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) < 2), $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle datapath: takes the datapath's PC, fetches the 32-bit instruction from a handshaked instruction memory, and drives the datapath's Instr input.
- Holds a one-entry fetch buffer (address plus data). While the current PC misses the buffer, it drives stall; the top level gates the PC register with stall.
- Detects misaligned PCs and memory-response timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT before bus_error is raised (range 2..255).
- NOP_INSTR, 32'h00000013: instruction driven while stalled or faulted (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- pc  input  32  current PC from datapath.
- instr  output  32  instruction to datapath.
- stall  output  1  high when instr is not valid for pc.
- misaligned  output  1  pc[1:0] != 0.
- bus_error  output  1  sticky response timeout.
- imem_req  output  1  request valid.
- imem_addr  output  32  request word address (byte address, [1:0]=0).
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  response data.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, imem_req=0, imem_addr=0, buf_valid=0, buf_addr=0, buf_data=0, req_addr=0, timer=0, bus_error=0. Reset has priority over every other event, including mid-REQ and mid-WAIT.
- hit = buf_valid && (pc == buf_addr), combinational.
- instr = hit ? buf_data : NOP_INSTR.
- stall = !hit.
- misaligned = (pc[1:0] != 0), combinational.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If !hit && !misaligned && !bus_error: go to REQ next cycle, registering imem_req=1, imem_addr=pc, req_addr=pc.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req=1 and imem_addr are held stable until imem_gnt==1 is sampled.
  - On gnt: imem_req=0, timer=0, go to WAIT.
  - pc changing during REQ does not alter imem_addr or cancel the request.
- WAIT:
  - timer increments each cycle.
  - On imem_rvalid: buf_addr=req_addr, buf_data=imem_rdata, buf_valid=1, go to IDLE.
  - If rvalid is absent and timer==TIMEOUT-1: bus_error=1, go to IDLE, buffer unchanged.
  - rvalid and timeout in the same cycle: rvalid wins, no error.
- imem_rvalid is ignored in IDLE and REQ. Stray or post-reset responses are discarded.
- Stale response: if pc has changed since the request (flush, jump or branch), the buffer is still filled with req_addr. The resulting miss then launches a new request from IDLE. Only one request is outstanding at any time.
- Misaligned pc: no request issued, stall=1, instr=NOP_INSTR. The condition clears when pc realigns.
- bus_error is sticky until reset. While set, no new requests are issued. A hit still delivers the buffered instr.
- Minimum miss latency, with gnt in the REQ cycle and rvalid on the next cycle: miss at cycle 0, REQ at cycle 1, WAIT/rvalid at cycle 2, hit and stall=0 at cycle 3.
- Address arithmetic: full 32-bit compare, no wrap handling. pc=32'hFFFFFFFC is fetched normally.

Test Plan:
- Reset, then pc=0; gnt immediate, rvalid 1 cycle after gnt with rdata=32'h00500113 -> imem_req=1 with addr 0 at cycle 1; stall=1 cycles 0–2; at cycle 3 instr=32'h00500113, stall=0.
- Hold pc=0 after the fill, then step pc to 4 -> hit with no imem_req while pc=0; pc=4 raises stall and a new request with imem_addr=4.
- gnt delayed 3 cycles while pc changes 8→12 during REQ -> imem_addr stays 8 until gnt. The fill is tagged 8; then a new request for 12 is issued, and instr is valid for 12 only after its own response.
- No rvalid after gnt, TIMEOUT=16 -> bus_error=1 on the 16th WAIT cycle; no further imem_req; stall stays 1 for a missing pc. Then reset=0 for one cycle -> bus_error=0 and the fetch restarts.
- pc=32'h00000006 -> misaligned=1, stall=1, instr=32'h00000013, imem_req never asserted. Then pc=8 -> normal fetch.
- Reset asserted during WAIT, followed by a late rvalid with rdata=32'hDEADBEEF -> response ignored, buf_valid=0; the next fetch of the same pc re-requests.
